imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 1024, size of the instruction memory in bytes.
REQ-002 Parameter NREQ, fixed 2: requester 0 is the core fetch unit, requester 1 is the debug/loader reader.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high.
REQ-005 Port req_valid, input, 2: bit n means requester n presents a read.
REQ-006 Port req_addr0 / req_addr1, input, 64 each: byte address of the requested instruction word.
REQ-007 Port req_ready, output, 2: bit n means the request from requester n is accepted this cycle.
REQ-008 Port rsp_valid, output, 2: bit n means the response register of requester n holds data.
REQ-009 Port rsp_data0 / rsp_data1, output, 32 each: instruction word.
REQ-010 Port rsp_err, output, 2: bit n means the held response is a fault.
REQ-011 Port rsp_ready, input, 2: bit n means requester n consumes its response this cycle.
REQ-012 Port mem_addr, output, 64: address driven to the combinational instruction memory.
REQ-013 Port mem_data, input, 32: word returned by the instruction memory in the same cycle.
REQ-014 Port grant_cnt0 / grant_cnt1, output, 16 each: saturating per-requester accept counters.

Function
REQ-015 Each requester owns a one-entry response slot with states EMPTY and FULL.
REQ-016 Requester n is eligible when req_valid[n]=1 and its slot is EMPTY, or its slot is FULL with rsp_ready[n]=1 in the same cycle.
REQ-017 At most one request is accepted per cycle; req_ready is one-hot or zero.
REQ-018 Only one eligible requester: it is granted.
REQ-019 Both eligible: round-robin; the requester not granted most recently wins.
REQ-020 last_grant updates only on an accept.
REQ-021 req_ready[n] is combinational from the current inputs and state; requesters hold valid and address stable until ready.
REQ-022 mem_addr equals the granted requester's address, or req_addr0 when nothing is granted.
REQ-023 Fault when addr[1:0]!=0 or addr > MEM_BYTES-4; a fault response has rsp_err=1 and rsp_data=0.
REQ-024 Non-fault response: rsp_data = mem_data sampled in the accept cycle, with rsp_err=0.
REQ-025 Latency: rsp_valid[n] rises on the clock edge after req_ready[n]=1, giving one-cycle latency.
REQ-026 A slot goes FULL to EMPTY on rsp_ready[n]=1 unless a new accept for n occurs in the same cycle; in that case it stays FULL with the new data.
REQ-027 rsp_ready[n] while the slot is EMPTY is ignored.
REQ-028 rsp_data and rsp_err hold their values while the slot is FULL and rsp_ready is 0.
REQ-029 grant_cnt[n] increments on each accept of n and saturates at 16'hFFFF.
REQ-030 Each slot drains independently; a stalled requester never blocks the other.

Reset
REQ-031 While reset=1: both slots EMPTY, rsp_valid=0, rsp_err=0, rsp_data=0, req_ready=0, grant counters 0.
REQ-032 On reset, last_grant is set to 1, so requester 0 wins the first contention.
REQ-033 Reset mid-transaction discards held responses; a request accepted in the same cycle as reset is dropped.

Structure
REQ-034 A shared package holds MEM_BYTES, the slot-state enum (EMPTY/FULL) and the requester index constants.
REQ-035 One sub-module, imem_rsp_slot, is instantiated per requester and holds state, data, err and the drain/refill logic.
REQ-036 Arbitration, fault check and counters stay in imem_arbiter.

Verification
REQ-037 Single read: reset, then req_valid=01 with addr0=0x8 and mem word 0xDEADBEEF. Required: req_ready=01 in cycle 0; next cycle rsp_valid=01, rsp_data0=0xDEADBEEF, rsp_err=00.
REQ-038 Contention: both requesters valid every cycle with rsp_ready=11. Required: grants alternate 0,1,0,1, and grant_cnt0=grant_cnt1=2 after 4 cycles.
REQ-039 Fault: addr1=0x6, then addr1=0x400. Required: both give rsp_err[1]=1 and rsp_data1=0.
REQ-040 Backpressure: requester 0 with rsp_ready[0]=0 and a second request pending. Required: req_ready[0]=0 and rsp_data0 stable, while requester 1 is still served. Raising rsp_ready[0] gives same-cycle accept and refill.
REQ-041 Reset mid-operation: reset asserted with both slots FULL. Required: rsp_valid=00 and counters 0 next cycle; the first post-reset contention is granted to requester 0.
REQ-042 Saturation: grant_cnt0 forced to 0xFFFE, then 3 accepts. Required: the counter stays at 0xFFFF.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the two-requester instruction-memory arbiter.
package imem_arbiter_pkg;

  localparam int unsigned DEFAULT_MEM_BYTES = 1024;

  // Requester indices: core fetch unit and debug/loader reader.
  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned REQ_CORE  = 0;
  localparam int unsigned REQ_DEBUG = 1;

  // Per-requester one-entry response slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/imem_rsp_slot.sv
// One-entry response holding register for a single requester.
// Refill on accept takes priority over drain, so a consume and a new
// accept in the same cycle leave the slot full with the new word.
module imem_rsp_slot
  import imem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        fault,
  input  logic [31:0] mem_data,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  slot_state_t state;

  // Slot state, data and fault flag: refill on accept, drain on consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SLOT_EMPTY;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      state    <= SLOT_FULL;
      rsp_data <= fault ? '0 : mem_data;
      rsp_err  <= fault;
    end else if (state == SLOT_FULL && rsp_ready) begin
      state <= SLOT_EMPTY;
    end
  end

  assign rsp_valid = (state == SLOT_FULL);

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one combinational instruction memory
// between the core fetch unit and the debug/loader reader.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES,
  parameter int unsigned NREQ      = NUM_REQ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic [63:0]     req_addr0,
  input  logic [63:0]     req_addr1,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] rsp_valid,
  output logic [31:0]     rsp_data0,
  output logic [31:0]     rsp_data1,
  output logic [NREQ-1:0] rsp_err,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [63:0]     mem_addr,
  input  logic [31:0]     mem_data,
  output logic [15:0]     grant_cnt0,
  output logic [15:0]     grant_cnt1
);

  localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 4);

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            last_grant;
  logic            fault;
  logic [15:0]     cnt [NREQ];

  // Eligibility, round-robin grant, memory address mux and fault check.
  always_comb begin
    eligible = req_valid & (~rsp_valid | rsp_ready);
    grant    = '0;
    if (!reset) begin
      if (&eligible) grant = last_grant ? 2'b01 : 2'b10;
      else           grant = eligible;
    end
    mem_addr = grant[REQ_DEBUG] ? req_addr1 : req_addr0;
    fault    = (mem_addr[1:0] != 2'b00) || (mem_addr > LAST_WORD);
  end

  assign req_ready = grant;

  // Remember who won most recently; reset favours the core on first contention.
  always_ff @(posedge clk) begin
    if (reset)      last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[REQ_DEBUG];
  end

  // Saturating per-requester accept counters.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (reset)                               cnt[i] <= '0;
      else if (grant[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
    end
  end

  assign grant_cnt0 = cnt[REQ_CORE];
  assign grant_cnt1 = cnt[REQ_DEBUG];

  imem_rsp_slot u_slot_core (
    .clk       (clk),
    .reset     (reset),
    .accept    (grant[REQ_CORE]),
    .fault     (fault),
    .mem_data  (mem_data),
    .rsp_ready (rsp_ready[REQ_CORE]),
    .rsp_valid (rsp_valid[REQ_CORE]),
    .rsp_data  (rsp_data0),
    .rsp_err   (rsp_err[REQ_CORE])
  );

  imem_rsp_slot u_slot_debug (
    .clk       (clk),
    .reset     (reset),
    .accept    (grant[REQ_DEBUG]),
    .fault     (fault),
    .mem_data  (mem_data),
    .rsp_ready (rsp_ready[REQ_DEBUG]),
    .rsp_valid (rsp_valid[REQ_DEBUG]),
    .rsp_data  (rsp_data1),
    .rsp_err   (rsp_err[REQ_DEBUG])
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed stimulus pushes expected
// responses, a monitor pops and compares them when a response is consumed.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_addr0 = '0;
  logic [63:0] req_addr1 = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data0;
  logic [31:0] rsp_data1;
  logic [1:0]  rsp_err;
  logic [1:0]  rsp_ready = '0;
  logic [63:0] mem_addr;
  logic [31:0] mem_data;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.MEM_BYTES(1024), .NREQ(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data0  (rsp_data0),
    .rsp_data1  (rsp_data1),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // Combinational memory model.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  assign mem_data = mem_word(mem_addr);

  function automatic rsp_t exp_rsp(input logic [63:0] a);
    rsp_t r;
    r.err  = (a[1:0] != 2'b00) || (a > 64'd1020);
    r.data = r.err ? 32'h0 : mem_word(a);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus with the hand-computed grant.
  task automatic step(input string name, input logic [1:0] v, input logic [63:0] a0,
                      input logic [63:0] a1, input logic [1:0] rr, input logic [1:0] er);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr0 = a0;
    req_addr1 = a1;
    rsp_ready = rr;
    @(negedge clk);
    chk({name, " req_ready"}, 64'(req_ready), 64'(er));
    chk({name, " mem_addr"}, mem_addr, er[1] ? a1 : a0);
    if (er[0]) q0.push_back(exp_rsp(a0));
    if (er[1]) q1.push_back(exp_rsp(a1));
  endtask

  task automatic do_reset(input logic [1:0] v);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = v;
    req_addr0 = 64'h8;
    req_addr1 = 64'h10;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset rsp_err", 64'(rsp_err), 64'h0);
    chk("reset rsp_data0", 64'(rsp_data0), 64'h0);
    chk("reset rsp_data1", 64'(rsp_data1), 64'h0);
    chk("reset grant_cnt0", 64'(grant_cnt0), 64'h0);
    chk("reset grant_cnt1", 64'(grant_cnt1), 64'h0);
    chk("reset req_ready held", 64'(req_ready), 64'h0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 2'b00;
  endtask

  // Monitor: compare each consumed response against the scoreboard.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid[0] && rsp_ready[0]) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp0 unexpected: got data 0x%0h expected no response", rsp_data0);
        end else begin
          e = q0.pop_front();
          chk("rsp0 data", 64'(rsp_data0), 64'(e.data));
          chk("rsp0 err", 64'(rsp_err[0]), 64'(e.err));
        end
      end
      if (!reset && rsp_valid[1] && rsp_ready[1]) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp1 unexpected: got data 0x%0h expected no response", rsp_data1);
        end else begin
          e = q1.pop_front();
          chk("rsp1 data", 64'(rsp_data1), 64'(e.data));
          chk("rsp1 err", 64'(rsp_err[1]), 64'(e.err));
        end
      end
    end
  end

  initial begin
    // Reset with requests pending: nothing may be accepted.
    do_reset(2'b11);

    // Single read, one-cycle latency.
    step("single", 2'b01, 64'h8, 64'h0, 2'b00, 2'b01);
    step("single drain", 2'b00, 64'h0, 64'h0, 2'b01, 2'b00);
    chk("single rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single rsp_err", 64'(rsp_err), 64'h0);
    chk("single rsp_data0", 64'(rsp_data0), 64'hDEADBEEF);

    // Contention after reset: 0,1,0,1.
    do_reset(2'b00);
    step("cont 0", 2'b11, 64'h10, 64'h20, 2'b11, 2'b01);
    step("cont 1", 2'b11, 64'h10, 64'h20, 2'b11, 2'b10);
    step("cont 2", 2'b11, 64'h10, 64'h20, 2'b11, 2'b01);
    step("cont 3", 2'b11, 64'h10, 64'h20, 2'b11, 2'b10);
    step("cont drain", 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);
    chk("cont grant_cnt0", 64'(grant_cnt0), 64'd2);
    chk("cont grant_cnt1", 64'(grant_cnt1), 64'd2);

    // Faults: misaligned, past end; last legal word is fine.
    step("fault misalign", 2'b10, 64'h0, 64'h6, 2'b11, 2'b10);
    step("fault range", 2'b10, 64'h0, 64'h400, 2'b11, 2'b10);
    chk("fault misalign err1", 64'(rsp_err[1]), 64'h1);
    chk("fault misalign data1", 64'(rsp_data1), 64'h0);
    step("last word", 2'b10, 64'h0, 64'h3FC, 2'b11, 2'b10);
    chk("fault range err1", 64'(rsp_err[1]), 64'h1);
    chk("fault range data1", 64'(rsp_data1), 64'h0);
    step("fault drain", 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);
    chk("last word err1", 64'(rsp_err[1]), 64'h0);
    chk("last word data1", 64'(rsp_data1), 64'hC0DE03FC);

    // Backpressure on requester 0 while requester 1 is served.
    step("bp fill", 2'b01, 64'h30, 64'h0, 2'b00, 2'b01);
    step("bp stall", 2'b11, 64'h34, 64'h40, 2'b00, 2'b10);
    chk("bp stall data0", 64'(rsp_data0), 64'hC0DE0030);
    chk("bp stall rsp_valid", 64'(rsp_valid), 64'h1);
    step("bp hold", 2'b01, 64'h34, 64'h0, 2'b10, 2'b00);
    chk("bp hold data0", 64'(rsp_data0), 64'hC0DE0030);
    step("bp refill", 2'b01, 64'h34, 64'h0, 2'b01, 2'b01);
    step("bp check", 2'b00, 64'h0, 64'h0, 2'b00, 2'b00);
    chk("bp refill rsp_valid", 64'(rsp_valid), 64'h1);
    chk("bp refill data0", 64'(rsp_data0), 64'hC0DE0034);
    step("bp drain", 2'b00, 64'h0, 64'h0, 2'b01, 2'b00);

    // Reset with both slots full; first contention afterwards goes to 0.
    step("pre-reset a", 2'b11, 64'h50, 64'h60, 2'b00, 2'b10);
    step("pre-reset b", 2'b11, 64'h50, 64'h60, 2'b00, 2'b01);
    chk("pre-reset rsp_valid", 64'(rsp_valid), 64'h2);
    do_reset(2'b11);
    step("post-reset cont", 2'b11, 64'h70, 64'h80, 2'b11, 2'b01);
    step("post-reset drain", 2'b00, 64'h0, 64'h0, 2'b11, 2'b00);

    // Counter saturation.
    do_reset(2'b00);
    for (int i = 0; i < 65534; i++)
      step("sat fill", 2'b01, 64'h100, 64'h0, 2'b01, 2'b01);
    step("sat x1", 2'b01, 64'h104, 64'h0, 2'b01, 2'b01);
    chk("sat cnt0 at FFFE", 64'(grant_cnt0), 64'hFFFE);
    step("sat x2", 2'b01, 64'h108, 64'h0, 2'b01, 2'b01);
    chk("sat cnt0 after 1", 64'(grant_cnt0), 64'hFFFF);
    step("sat x3", 2'b01, 64'h10C, 64'h0, 2'b01, 2'b01);
    chk("sat cnt0 after 2", 64'(grant_cnt0), 64'hFFFF);
    step("sat drain", 2'b00, 64'h0, 64'h0, 2'b01, 2'b00);
    chk("sat cnt0 after 3", 64'(grant_cnt0), 64'hFFFF);
    chk("sat cnt1", 64'(grant_cnt1), 64'h0);

    @(posedge clk);
    #1;
    chk("scoreboard q0 empty", 64'(q0.size()), 64'h0);
    chk("scoreboard q1 empty", 64'(q1.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
